// File: rtl/mips_cpu_bus_arbiter_if.sv
// Signal bundle between the bus arbiter, its two requesters (fetch F, load/store D)
// and the shared Avalon-style memory bus.
interface mips_cpu_bus_arbiter_if;
   // Fetch requester
   logic        f_req;
   logic [31:0] f_addr;
   logic        f_ack;
   logic [31:0] f_rdata;
   // Data requester
   logic        d_req;
   logic        d_write;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [3:0]  d_byteenable;
   logic        d_ack;
   logic [31:0] d_rdata;
   // Status
   logic        err;
   logic        busy;
   // Memory bus
   logic [31:0] address;
   logic        write;
   logic        read;
   logic        waitrequest;
   logic [31:0] writedata;
   logic [3:0]  byteenable;
   logic [31:0] readdata;

   // Arbiter side: masters the memory bus, serves the requesters
   modport master (
      input  f_req, f_addr, d_req, d_write, d_addr, d_wdata, d_byteenable,
      input  waitrequest, readdata,
      output f_ack, f_rdata, d_ack, d_rdata, err, busy,
      output address, write, read, writedata, byteenable
   );

   // Requester / memory side
   modport slave (
      output f_req, f_addr, d_req, d_write, d_addr, d_wdata, d_byteenable,
      output waitrequest, readdata,
      input  f_ack, f_rdata, d_ack, d_rdata, err, busy,
      input  address, write, read, writedata, byteenable
   );
endinterface

// File: rtl/mips_cpu_bus_arbiter.sv
// Round-robin arbiter sharing one memory bus between instruction fetch (F) and
// load/store (D). Each transaction is latched in IDLE, held on the bus through
// ACCESS while waitrequest is high, and acknowledged with a one-cycle pulse in RESP.
// A watchdog forces completion (with err) after WAIT_TIMEOUT stalled cycles.
module mips_cpu_bus_arbiter #(
   parameter int unsigned WAIT_TIMEOUT = 1024,  // 0 disables the watchdog
   parameter bit          RESET_FIRST  = 1'b0   // 0: F wins first tie, 1: D wins
) (
   input logic                    clk,
   input logic                    reset,        // active low, asynchronous
   mips_cpu_bus_arbiter_if.master bus
);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   // Grant encoding: 0 = F, 1 = D
   localparam logic LastGrantRst = ~RESET_FIRST;

   state_e      state_q, state_d;
   logic        last_grant_q, last_grant_d;
   logic        grant_q, grant_d;
   logic [31:0] addr_q, addr_d;
   logic        read_q, read_d;
   logic        write_q, write_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wd_cnt_q, wd_cnt_d;
   logic        f_ack_q, f_ack_d;
   logic        d_ack_q, d_ack_d;
   logic        err_q, err_d;
   logic [31:0] f_rdata_q, f_rdata_d;
   logic [31:0] d_rdata_q, d_rdata_d;
   logic        timeout;
   logic [31:0] resp_data;

   // Watchdog fires on the last permitted stalled ACCESS cycle
   assign timeout = (WAIT_TIMEOUT != 0) && (wd_cnt_q == 32'(WAIT_TIMEOUT - 1));

   // Next-state, grant selection and transaction latching
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_d      = grant_q;
      addr_d       = addr_q;
      read_d       = read_q;
      write_d      = write_q;
      wdata_d      = wdata_q;
      be_d         = be_q;
      wd_cnt_d     = wd_cnt_q;
      f_ack_d      = 1'b0;
      d_ack_d      = 1'b0;
      err_d        = 1'b0;
      f_rdata_d    = f_rdata_q;
      d_rdata_d    = d_rdata_q;
      resp_data    = 32'h0;

      case (state_q)
         StIdle: begin
            if (bus.f_req || bus.d_req) begin
               // On a tie, serve whoever did not win last time
               grant_d      = (bus.f_req && bus.d_req) ? ~last_grant_q : bus.d_req;
               last_grant_d = grant_d;
               wd_cnt_d     = 32'h0;
               state_d      = StAccess;
               if (grant_d) begin
                  read_d  = ~bus.d_write;
                  write_d = bus.d_write;
                  addr_d  = {bus.d_addr[31:2], 2'b00};
                  wdata_d = bus.d_write ? bus.d_wdata : 32'h0;
                  be_d    = bus.d_byteenable;
               end else begin
                  read_d  = 1'b1;
                  write_d = 1'b0;
                  addr_d  = {bus.f_addr[31:2], 2'b00};
                  wdata_d = 32'h0;
                  be_d    = 4'hf;
               end
            end
         end
         StAccess: begin
            if (!bus.waitrequest || timeout) begin
               // Timed-out transactions and writes return zero data
               if (!bus.waitrequest && read_q) resp_data = bus.readdata;
               err_d   = bus.waitrequest;
               read_d  = 1'b0;
               write_d = 1'b0;
               state_d = StResp;
               if (grant_q) begin
                  d_ack_d   = 1'b1;
                  d_rdata_d = resp_data;
               end else begin
                  f_ack_d   = 1'b1;
                  f_rdata_d = resp_data;
               end
            end else begin
               wd_cnt_d = wd_cnt_q + 32'h1;
            end
         end
         StResp: begin
            wd_cnt_d = 32'h0;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= StIdle;
         last_grant_q <= LastGrantRst;
         grant_q      <= 1'b0;
         addr_q       <= 32'h0;
         read_q       <= 1'b0;
         write_q      <= 1'b0;
         wdata_q      <= 32'h0;
         be_q         <= 4'h0;
         wd_cnt_q     <= 32'h0;
         f_ack_q      <= 1'b0;
         d_ack_q      <= 1'b0;
         err_q        <= 1'b0;
         f_rdata_q    <= 32'h0;
         d_rdata_q    <= 32'h0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_q      <= grant_d;
         addr_q       <= addr_d;
         read_q       <= read_d;
         write_q      <= write_d;
         wdata_q      <= wdata_d;
         be_q         <= be_d;
         wd_cnt_q     <= wd_cnt_d;
         f_ack_q      <= f_ack_d;
         d_ack_q      <= d_ack_d;
         err_q        <= err_d;
         f_rdata_q    <= f_rdata_d;
         d_rdata_q    <= d_rdata_d;
      end
   end

   assign bus.address    = addr_q;
   assign bus.read       = read_q;
   assign bus.write      = write_q;
   assign bus.writedata  = wdata_q;
   assign bus.byteenable = be_q;
   assign bus.f_ack      = f_ack_q;
   assign bus.d_ack      = d_ack_q;
   assign bus.f_rdata    = f_rdata_q;
   assign bus.d_rdata    = d_rdata_q;
   assign bus.err        = err_q;
   assign bus.busy       = (state_q != StIdle);

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// Directed bench for mips_cpu_bus_arbiter, watchdog shortened to 8 cycles.
module tb_mips_cpu_bus_arbiter;

   logic clk;
   logic reset;
   int   tests;
   int   fails;

   mips_cpu_bus_arbiter_if bus ();

   mips_cpu_bus_arbiter #(
      .WAIT_TIMEOUT (8),
      .RESET_FIRST  (1'b0)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and settle just after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      bus.f_req = 0; bus.f_addr = 0; bus.d_req = 0; bus.d_write = 0; bus.d_addr = 0;
      bus.d_wdata = 0; bus.d_byteenable = 0; bus.waitrequest = 0; bus.readdata = 0;
      repeat (2) step();
      tests++; if (bus.read !== 1'b0) begin fails++; $display("FAIL reset_read: got %b want 0", bus.read); end
      tests++; if (bus.write !== 1'b0) begin fails++; $display("FAIL reset_write: got %b want 0", bus.write); end
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      tests++; if ({bus.f_ack, bus.d_ack, bus.err} !== 3'b000) begin fails++; $display("FAIL reset_ack_err: got %b want 000", {bus.f_ack, bus.d_ack, bus.err}); end
      tests++; if (bus.address !== 32'h0) begin fails++; $display("FAIL reset_address: got %h want 0", bus.address); end
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_fetch();
      bus.f_req = 1; bus.f_addr = 32'hBFC00000; bus.waitrequest = 0; bus.readdata = 32'h3C03BFC0;
      step();
      tests++; if (bus.read !== 1'b1 || bus.write !== 1'b0) begin fails++; $display("FAIL fetch_strobe: got r%b w%b want r1 w0", bus.read, bus.write); end
      tests++; if (bus.address !== 32'hBFC00000) begin fails++; $display("FAIL fetch_addr: got %h want bfc00000", bus.address); end
      tests++; if (bus.byteenable !== 4'hf) begin fails++; $display("FAIL fetch_be: got %b want 1111", bus.byteenable); end
      tests++; if (bus.f_ack !== 1'b0) begin fails++; $display("FAIL fetch_early_ack: got %b want 0", bus.f_ack); end
      step();
      tests++; if (bus.f_ack !== 1'b1 || bus.d_ack !== 1'b0) begin fails++; $display("FAIL fetch_ack: got f%b d%b want f1 d0", bus.f_ack, bus.d_ack); end
      tests++; if (bus.f_rdata !== 32'h3C03BFC0) begin fails++; $display("FAIL fetch_rdata: got %h want 3c03bfc0", bus.f_rdata); end
      tests++; if (bus.read !== 1'b0 || bus.err !== 1'b0) begin fails++; $display("FAIL fetch_resp: got r%b e%b want 0 0", bus.read, bus.err); end
      bus.f_req = 0;
      step();
      tests++; if (bus.f_ack !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL fetch_idle: got ack%b busy%b want 0 0", bus.f_ack, bus.busy); end
   endtask

   task automatic test_store();
      bus.d_req = 1; bus.d_write = 1; bus.d_addr = 32'h00000013; bus.d_wdata = 32'h12345678;
      bus.d_byteenable = 4'b0010; bus.waitrequest = 1; bus.readdata = 32'hFFFF0000;
      step();
      for (int i = 1; i <= 5; i++) begin
         if (i == 5) bus.waitrequest = 0;
         bus.d_wdata = 32'hDEAD0000 | i;  // must not leak onto the bus
         tests++;
         if (bus.address !== 32'h10 || bus.write !== 1'b1 || bus.read !== 1'b0 ||
             bus.writedata !== 32'h12345678 || bus.byteenable !== 4'b0010) begin
            fails++;
            $display("FAIL store_hold[%0d]: got a=%h w%b r%b wd=%h be=%b want a=10 w1 r0 wd=12345678 be=0010",
                     i, bus.address, bus.write, bus.read, bus.writedata, bus.byteenable);
         end
         tests++; if (bus.d_ack !== 1'b0 || bus.f_ack !== 1'b0) begin fails++; $display("FAIL store_early_ack[%0d]: got f%b d%b want 0 0", i, bus.f_ack, bus.d_ack); end
         step();
      end
      tests++; if (bus.d_ack !== 1'b1 || bus.f_ack !== 1'b0) begin fails++; $display("FAIL store_ack: got f%b d%b want f0 d1", bus.f_ack, bus.d_ack); end
      tests++; if (bus.write !== 1'b0) begin fails++; $display("FAIL store_write_drop: got %b want 0", bus.write); end
      tests++; if (bus.d_rdata !== 32'h0) begin fails++; $display("FAIL store_rdata: got %h want 0", bus.d_rdata); end
      tests++; if (bus.f_rdata !== 32'h3C03BFC0) begin fails++; $display("FAIL store_f_rdata_hold: got %h want 3c03bfc0", bus.f_rdata); end
      bus.d_req = 0;
      step();
      tests++; if (bus.d_ack !== 1'b0) begin fails++; $display("FAIL store_single_pulse: got %b want 0", bus.d_ack); end
   endtask

   task automatic test_back_to_back();
      logic exp_f;
      logic exp_d;
      bus.f_req = 1; bus.f_addr = 32'h00000100; bus.d_req = 1; bus.d_write = 0;
      bus.d_addr = 32'h00000204; bus.d_byteenable = 4'hf; bus.waitrequest = 0;
      bus.readdata = 32'hA5A50001;
      for (int k = 1; k <= 11; k++) begin
         step();
         exp_f = (k == 2) || (k == 8);
         exp_d = (k == 5) || (k == 11);
         tests++; if (bus.f_ack !== exp_f || bus.d_ack !== exp_d) begin fails++; $display("FAIL rr_ack[%0d]: got f%b d%b want f%b d%b", k, bus.f_ack, bus.d_ack, exp_f, exp_d); end
         if (k == 1 || k == 7) begin
            tests++; if (bus.address !== 32'h100 || bus.read !== 1'b1) begin fails++; $display("FAIL rr_grant_f[%0d]: got a=%h r%b want a=100 r1", k, bus.address, bus.read); end
         end
         if (k == 4 || k == 10) begin
            tests++; if (bus.address !== 32'h204 || bus.read !== 1'b1) begin fails++; $display("FAIL rr_grant_d[%0d]: got a=%h r%b want a=204 r1", k, bus.address, bus.read); end
         end
      end
      tests++; if (bus.d_rdata !== 32'hA5A50001) begin fails++; $display("FAIL rr_d_rdata: got %h want a5a50001", bus.d_rdata); end
      bus.f_req = 0; bus.d_req = 0;
      repeat (2) step();
      tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL rr_idle: got busy %b want 0", bus.busy); end
   endtask

   task automatic test_timeout();
      bus.d_req = 1; bus.d_write = 0; bus.d_addr = 32'h00000040; bus.waitrequest = 1;
      bus.readdata = 32'h77777777;
      step();
      for (int i = 1; i <= 8; i++) begin
         tests++; if (bus.read !== 1'b1 || bus.d_ack !== 1'b0) begin fails++; $display("FAIL wd_stall[%0d]: got r%b ack%b want r1 ack0", i, bus.read, bus.d_ack); end
         step();
      end
      tests++; if (bus.read !== 1'b0) begin fails++; $display("FAIL wd_read_drop: got %b want 0", bus.read); end
      tests++; if (bus.d_ack !== 1'b1 || bus.err !== 1'b1) begin fails++; $display("FAIL wd_ack_err: got ack%b err%b want 1 1", bus.d_ack, bus.err); end
      tests++; if (bus.d_rdata !== 32'h0) begin fails++; $display("FAIL wd_rdata: got %h want 0", bus.d_rdata); end
      bus.d_req = 0; bus.waitrequest = 0;
      step();
      tests++; if (bus.err !== 1'b0 || bus.d_ack !== 1'b0) begin fails++; $display("FAIL wd_err_clear: got err%b ack%b want 0 0", bus.err, bus.d_ack); end
      bus.f_req = 1; bus.f_addr = 32'h0000000B; bus.readdata = 32'hDEADBEEF;
      step();
      tests++; if (bus.address !== 32'h8) begin fails++; $display("FAIL wd_next_addr: got %h want 00000008", bus.address); end
      step();
      tests++; if (bus.f_ack !== 1'b1 || bus.err !== 1'b0 || bus.f_rdata !== 32'hDEADBEEF) begin fails++; $display("FAIL wd_next_fetch: got ack%b err%b d=%h want 1 0 deadbeef", bus.f_ack, bus.err, bus.f_rdata); end
      bus.f_req = 0;
      step();
   endtask

   task automatic test_reset_mid();
      bus.f_req = 1; bus.f_addr = 32'h00000020; bus.waitrequest = 1;
      step();
      tests++; if (bus.read !== 1'b1) begin fails++; $display("FAIL mid_access: got r%b want 1", bus.read); end
      #2 reset = 1'b0;
      #1;
      tests++; if (bus.read !== 1'b0 || bus.write !== 1'b0 || bus.busy !== 1'b0) begin fails++; $display("FAIL mid_async: got r%b w%b busy%b want 0 0 0", bus.read, bus.write, bus.busy); end
      tests++; if (bus.f_ack !== 1'b0 || bus.f_rdata !== 32'h0) begin fails++; $display("FAIL mid_async_ack: got ack%b d=%h want 0 0", bus.f_ack, bus.f_rdata); end
      bus.f_req = 0; bus.waitrequest = 0;
      @(negedge clk);
      reset = 1'b1;
      step();
      tests++; if (bus.f_ack !== 1'b0 || bus.read !== 1'b0) begin fails++; $display("FAIL mid_no_stale: got ack%b r%b want 0 0", bus.f_ack, bus.read); end
      // Tie right after reset must go to F
      bus.f_req = 1; bus.f_addr = 32'h00000024; bus.d_req = 1; bus.d_addr = 32'h00000300;
      bus.readdata = 32'h0BADF00D;
      step();
      tests++; if (bus.address !== 32'h24 || bus.read !== 1'b1) begin fails++; $display("FAIL mid_refetch_addr: got a=%h r%b want a=24 r1", bus.address, bus.read); end
      step();
      tests++; if (bus.f_ack !== 1'b1 || bus.d_ack !== 1'b0 || bus.f_rdata !== 32'h0BADF00D) begin fails++; $display("FAIL mid_refetch: got f%b d%b d=%h want 1 0 0badf00d", bus.f_ack, bus.d_ack, bus.f_rdata); end
      bus.f_req = 0; bus.d_req = 0;
      step();
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_fetch();
      test_store();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
